// File: rtl/cordic_inv_af.sv
// Iterative hyperbolic-vectoring CORDIC computing atanh(y), or logit(p) when CORDIC_INV_LOGIT_EN
// is defined (sel=0 then maps p to 2p-1 and doubles the angle). One micro-step per cycle.
module cordic_inv_af #(
  parameter int n         = 8,
  parameter int FRAC_BITS = 4,
  parameter int ITER      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] y_in,
  input  logic         sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] z_out,
  output logic         sat
);

  localparam int SH   = 12 - FRAC_BITS;
  localparam int RND  = 1 << (SH - 1);
  localparam int MAXV = (1 << (n - 1)) - 1;
  localparam int MINV = -(1 << (n - 1));

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q;
  logic signed [15:0] x_q, y_q, z_q;
  logic [3:0]         cnt_q;
  logic               oor_q, neg_q;

  // Q4.12 atanh(2^-i), rounded to nearest
  function automatic logic signed [15:0] atanh_lut(input logic [3:0] i);
    case (i)
      4'd1:    atanh_lut = 16'sd2250;
      4'd2:    atanh_lut = 16'sd1046;
      4'd3:    atanh_lut = 16'sd515;
      4'd4:    atanh_lut = 16'sd256;
      4'd5:    atanh_lut = 16'sd128;
      4'd6:    atanh_lut = 16'sd64;
      4'd7:    atanh_lut = 16'sd32;
      4'd8:    atanh_lut = 16'sd16;
      4'd9:    atanh_lut = 16'sd8;
      4'd10:   atanh_lut = 16'sd4;
      4'd11:   atanh_lut = 16'sd2;
      4'd12:   atanh_lut = 16'sd1;
      default: atanh_lut = 16'sd0;
    endcase
  endfunction

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  // Operand conditioning, done in 32 bits so the range check sees the true value
  logic signed [31:0] y_ext, y_sh, y0_w;
  logic               oor;

`ifdef CORDIC_INV_LOGIT_EN
  logic logit_q;
`else
  logic unused_sel;
  assign unused_sel = sel;
`endif

  always_comb begin
    y_ext = {{(32 - n){y_in[n-1]}}, y_in};
    y_sh  = y_ext <<< SH;
`ifdef CORDIC_INV_LOGIT_EN
    y0_w  = sel ? y_sh : (y_sh <<< 1) - 32'sd4096;
`else
    y0_w  = y_sh;
`endif
    oor   = (y0_w > 32'sd3072) || (y0_w < -32'sd3072);
  end

  // Micro-step: shift index sequence 1,2,3,4,4,5..ITER
  logic [3:0]         sh_amt;
  logic signed [15:0] xs, ys, at, x_nx, y_nx, z_nx;

  always_comb begin
    sh_amt = (cnt_q <= 4'd3) ? cnt_q + 4'd1 : cnt_q;
    xs     = x_q >>> sh_amt;
    ys     = y_q >>> sh_amt;
    at     = atanh_lut(sh_amt);
    if (y_q[15]) begin
      x_nx = x_q + ys;
      y_nx = y_q + xs;
      z_nx = z_q - at;
    end else begin
      x_nx = x_q - ys;
      y_nx = y_q - xs;
      z_nx = z_q + at;
    end
  end

  // Final angle: optional doubling, round half-up to FRAC_BITS, saturate to n bits
  logic signed [31:0] zr, zrnd;
  logic [n-1:0]       zq;

  always_comb begin
    zr = {{16{z_nx[15]}}, z_nx};
`ifdef CORDIC_INV_LOGIT_EN
    if (!logit_q) zr = zr <<< 1;
`endif
    zrnd = (zr + RND) >>> SH;
    if (zrnd > MAXV)      zq = n'(MAXV);
    else if (zrnd < MINV) zq = n'(MINV);
    else                  zq = n'(zrnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      oor_q   <= 1'b0;
      neg_q   <= 1'b0;
      z_out   <= '0;
      sat     <= 1'b0;
`ifdef CORDIC_INV_LOGIT_EN
      logit_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= StRun;
            x_q     <= 16'sd4096;
            y_q     <= y0_w[15:0];
            z_q     <= '0;
            cnt_q   <= '0;
            oor_q   <= oor;
            neg_q   <= y0_w[31];
`ifdef CORDIC_INV_LOGIT_EN
            logit_q <= sel;
`endif
          end
        end
        StRun: begin
          x_q   <= x_nx;
          y_q   <= y_nx;
          z_q   <= z_nx;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(ITER)) begin
            state_q <= StDone;
            z_out   <= oor_q ? (neg_q ? n'(-MAXV) : n'(MAXV)) : zq;
            sat     <= oor_q;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_inv_af.sv
// Scoreboard bench for cordic_inv_af: expected results queued at issue, compared on out_valid.
module tb_cordic_inv_af;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y_in = '0;
  logic       sel = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] z_out;
  logic       sat;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] z;
    logic       s;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  cordic_inv_af #(.n(8), .FRAC_BITS(4), .ITER(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out),
    .sat       (sat)
  );

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Drive one operand, queue its expectation, scramble inputs, wait for out_valid
  task automatic issue(input logic [7:0] y, input logic s, input logic [7:0] ez, input logic es);
    exp_t e;
    int   lat;
    @(negedge clk);
    in_valid = 1'b1;
    y_in     = y;
    sel      = s;
    e.z      = ez;
    e.s      = es;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    y_in     = ~y;
    sel      = ~s;
    check("busy_after_accept", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
  endtask

  task automatic take();
    exp_t e;
    check("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("z_out", int'(z_out), int'(e.z));
      check("sat", int'(sat), int'(e.s));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_take", int'(in_ready), 1);
    check("ov_dropped", int'(out_valid), 0);
  endtask

  initial begin
    int seen;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_z_out", int'(z_out), 0);
    check("rst_sat", int'(sat), 0);

    issue(8'h08, 1'b1, 8'h09, 1'b0); take();
    issue(8'hF8, 1'b1, 8'hF7, 1'b0); take();
    issue(8'h00, 1'b1, 8'h00, 1'b0); take();
    issue(8'h0C, 1'b1, 8'h10, 1'b0); take();  // |y0| = 0.75 exactly: still in range
    issue(8'h0E, 1'b1, 8'h7F, 1'b1); take();
    issue(8'hF2, 1'b1, 8'h81, 1'b1); take();
`ifdef CORDIC_INV_LOGIT_EN
    issue(8'h0C, 1'b0, 8'h12, 1'b0); take();
    issue(8'h00, 1'b0, 8'h81, 1'b1); take();
`else
    issue(8'h08, 1'b0, 8'h09, 1'b0); take();
    issue(8'h00, 1'b0, 8'h00, 1'b0); take();
`endif

    // Output held in DONE while a second operand is offered
    issue(8'h08, 1'b1, 8'h09, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      y_in     = 8'h0E;
      @(negedge clk);
      check("hold_z_out", int'(z_out), 9);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    take();
    @(negedge clk);
    check("ignored_operand", int'(in_ready), 1);

    // Reset three cycles into RUN discards the operation
    in_valid = 1'b1;
    y_in     = 8'h08;
    sel      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_z_out", int'(z_out), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_result", seen, 0);

    // Reset beats a simultaneous in_valid
    rst      = 1'b1;
    in_valid = 1'b1;
    y_in     = 8'h08;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_wins_ready", int'(in_ready), 1);
    @(negedge clk);
    check("rst_wins_idle", int'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
